pword_entry: RTL and testbench

PWORD_ENTRY -- requirements
Module: pword_entry

---
 rtl/pword_entry_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/pword_entry.sv | 134 +++++++++++++
 tb/tb_pword_entry.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pword_entry_pkg.sv
// Shared definitions for the password-entry front end and the access controller.
package pword_entry_pkg;

  typedef enum logic [1:0] {
    StEntry    = 2'd0,
    StWaitRes  = 2'd1,
    StLoggedIn = 2'd2,
    StLockout  = 2'd3
  } pw_state_e;

  localparam int unsigned NumDigits = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, counting debouncer and falling-edge detect for an
// active-low pushbutton. press pulses for one cycle when the debounced level drops.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntLast) begin
      done    = 1'b1;
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign press = done & ~sync2_q;

endmodule

// File: rtl/pword_entry.sv
// Password digit entry: debounced button strobes sw_digit to the access
// controller, tracks the attempt, and locks out after repeated failures.
module pword_entry
  import pword_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned RESULT_WAIT     = 4,
  parameter int unsigned MAX_FAILS       = 3,
  parameter int unsigned LOCK_CYCLES     = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] sw_digit,
  input  logic       btn_enter,
  input  logic       pass_green,
  output logic [3:0] pword,
  output logic       pword_enter,
  output logic [2:0] digit_count,
  output logic [1:0] fail_count,
  output logic       locked
);

  localparam int unsigned CntMax = max3(DEBOUNCE_CYCLES, RESULT_WAIT, LOCK_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ResultLoad = CntW'(RESULT_WAIT);
  localparam logic [CntW-1:0] LockLoad   = CntW'(LOCK_CYCLES);
  localparam logic [CntW-1:0] TimerOne   = CntW'(1);
  localparam logic [2:0]      DigitLast  = 3'(NumDigits - 1);
  localparam logic [1:0]      FailMax    = 2'(MAX_FAILS);

  pw_state_e       state_q, state_d;
  logic [CntW-1:0] timer_q, timer_d;
  logic [2:0]      digit_q, digit_d;
  logic [1:0]      fail_q, fail_d, fail_inc;
  logic [3:0]      pword_q;
  logic            pword_enter_q;
  logic            press;
  logic            accept;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CntW)
  ) u_btn_debounce (
    .CLK  (CLK),
    .RST  (RST),
    .btn_n(btn_enter),
    .press(press)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= StEntry;
      timer_q       <= '0;
      digit_q       <= '0;
      fail_q        <= '0;
      pword_q       <= '0;
      pword_enter_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      digit_q       <= digit_d;
      fail_q        <= fail_d;
      pword_enter_q <= accept;
      if (accept) pword_q <= sw_digit;
    end
  end

  // Presses are judged against state_q, so a transition on the same edge never steals one.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    digit_d  = digit_q;
    fail_d   = fail_q;
    fail_inc = (fail_q >= FailMax) ? fail_q : fail_q + 2'd1;
    unique case (state_q)
      StEntry: begin
        if (accept) begin
          digit_d = digit_q + 3'd1;
          if (digit_q == DigitLast) begin
            state_d = StWaitRes;
            timer_d = ResultLoad;
          end
        end
      end
      StWaitRes: begin
        if (pass_green) begin
          state_d = StLoggedIn;
          fail_d  = '0;
          digit_d = '0;
          timer_d = '0;
        end else if (timer_q <= TimerOne) begin
          digit_d = '0;
          fail_d  = fail_inc;
          timer_d = '0;
          if (fail_inc >= FailMax) begin
            state_d = StLockout;
            timer_d = LockLoad;
          end else begin
            state_d = StEntry;
          end
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
      StLoggedIn: begin
        if (accept || !pass_green) begin
          state_d = StEntry;
          digit_d = '0;
        end
      end
      StLockout: begin
        if (timer_q <= TimerOne) begin
          state_d = StEntry;
          fail_d  = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TimerOne;
        end
      end
    endcase
  end

  always_comb begin
    accept = press & ((state_q == StEntry) | (state_q == StLoggedIn));
    locked = (state_q == StLockout);
  end

  assign pword       = pword_q;
  assign pword_enter = pword_enter_q;
  assign digit_count = digit_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_pword_entry.sv
// Randomized bench for pword_entry: button bounce, digit attempts, login/logout,
// lockout and asynchronous reset, checked against an attempt-level model.
module tb_pword_entry;

  localparam int unsigned Deb = 4;
  localparam int unsigned Rw  = 4;
  localparam int          Mf  = 3;
  localparam int          Lc  = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] sw_digit = 4'd0;
  logic       btn_enter = 1'b1;
  logic       pass_green = 1'b0;
  logic [3:0] pword;
  logic       pword_enter;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  logic       locked;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_strobe = 0;
  int         since = 1000;
  int         green_after = -1;
  int         lock_seen = 0;
  logic [3:0] got_pword = 4'd0;
  int         m_dc = 0;
  int         m_fc = 0;

  pword_entry #(
    .DEBOUNCE_CYCLES(Deb),
    .RESULT_WAIT    (Rw),
    .MAX_FAILS      (Mf),
    .LOCK_CYCLES    (Lc)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .sw_digit   (sw_digit),
    .btn_enter  (btn_enter),
    .pass_green (pass_green),
    .pword      (pword),
    .pword_enter(pword_enter),
    .digit_count(digit_count),
    .fail_count (fail_count),
    .locked     (locked)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock; sample just after the edge and track strobes, lockout and green timing.
  task automatic step();
    @(posedge CLK);
    #1;
    if (pword_enter) begin
      n_strobe++;
      got_pword = pword;
      since = 0;
    end else if (since < 1000) begin
      since++;
    end
    if (locked) lock_seen++;
    if (green_after >= 0 && since == green_after) begin
      pass_green  = 1'b1;
      green_after = -1;
    end
  endtask

  task automatic press(input logic [3:0] d, input int pre_b, input int low_len,
                       input int rel_b, input int high_len);
    sw_digit = d;
    for (int i = 0; i < pre_b; i++) begin
      btn_enter = 1'($urandom_range(0, 1));
      step();
    end
    btn_enter = 1'b0;
    repeat (low_len) step();
    for (int i = 0; i < rel_b; i++) begin
      btn_enter = 1'($urandom_range(0, 1));
      step();
    end
    btn_enter = 1'b1;
    repeat (high_len) step();
    sw_digit = 4'($urandom_range(0, 15));
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_pword"}, int'(pword), 0);
    check_eq({tag, "_strobe"}, int'(pword_enter), 0);
    check_eq({tag, "_digits"}, int'(digit_count), 0);
    check_eq({tag, "_fails"}, int'(fail_count), 0);
    check_eq({tag, "_locked"}, int'(locked), 0);
  endtask

  task automatic lockout_phase();
    int s0;
    check_eq("lock_entry", int'(locked), 1);
    s0 = n_strobe;
    press(4'($urandom_range(0, 15)), 0, 8, 0, 8);
    check_eq("lock_press_strobe", n_strobe - s0, 0);
    for (int k = 0; k < 40 && locked; k++) step();
    check_eq("lock_release", int'(locked), 0);
    check_eq("lock_cycles", lock_seen, Lc);
    m_fc = 0;
    check_eq("lock_fail_clear", int'(fail_count), 0);
  endtask

  // Four digits; the 4th press either gets pass_green gdel cycles after its strobe or times out.
  task automatic attempt(input bit pass, input int gdel, input bit abort_lock);
    logic [3:0] d;
    int         s0;
    bit         last;
    lock_seen = 0;
    for (int i = 0; i < 4; i++) begin
      d    = 4'($urandom_range(0, 15));
      s0   = n_strobe;
      last = (i == 3) && !pass && (m_fc == Mf - 1);
      if (i == 3 && pass) begin
        since       = 1000;
        green_after = gdel;
      end
      if (last) press(d, 0, 8, 0, 7);
      else press(d, $urandom_range(0, 3), 8, $urandom_range(0, 3), 8);
      check_eq("digit_strobe", n_strobe - s0, 1);
      check_eq("digit_pword", int'(got_pword), int'(d));
      if (i < 3) begin
        m_dc++;
      end else begin
        m_dc = 0;
        if (pass) m_fc = 0;
        else if (m_fc < Mf) m_fc++;
      end
      check_eq("digit_count", int'(digit_count), m_dc);
      check_eq("fail_count", int'(fail_count), m_fc);
      check_eq("locked", int'(locked), (m_fc == Mf) ? 1 : 0);
    end
    if (m_fc == Mf && !abort_lock) lockout_phase();
  endtask

  task automatic logout(input bit by_press);
    logic [3:0] d;
    int         s0;
    if (by_press) begin
      d  = 4'($urandom_range(0, 15));
      s0 = n_strobe;
      press(d, $urandom_range(0, 3), 8, $urandom_range(0, 3), 8);
      check_eq("logout_strobe", n_strobe - s0, 1);
      check_eq("logout_pword", int'(got_pword), int'(d));
      check_eq("logout_digits", int'(digit_count), 0);
      pass_green = 1'b0;
    end else begin
      pass_green = 1'b0;
      repeat (3) step();
      check_eq("drop_digits", int'(digit_count), 0);
    end
    m_dc = 0;
  endtask

  initial begin
    int         s0;
    logic [3:0] seq [3];
    bit         pass;
    seq[0] = 4'd1;
    seq[1] = 4'd5;
    seq[2] = 4'd3;

    #1 RST = 1'b0;
    #1 check_reset_outs("rst");
    step();
    step();
    RST = 1'b1;
    step();
    step();

    // Bounced first press of digit 3.
    s0 = n_strobe;
    sw_digit  = 4'd3;
    btn_enter = 1'b0; step();
    btn_enter = 1'b1; step();
    btn_enter = 1'b0; step();
    repeat (8) step();
    btn_enter = 1'b1;
    repeat (8) step();
    check_eq("bounce_strobe", n_strobe - s0, 1);
    check_eq("bounce_pword", int'(got_pword), 3);
    check_eq("bounce_digits", int'(digit_count), 1);
    m_dc = 1;

    // Complete 3,1,5,3 with pass_green two cycles after the last strobe.
    for (int i = 0; i < 3; i++) begin
      s0 = n_strobe;
      if (i == 2) begin
        since       = 1000;
        green_after = 2;
      end
      press(seq[i], $urandom_range(0, 3), 8, $urandom_range(0, 3), 8);
      check_eq("login_strobe", n_strobe - s0, 1);
      check_eq("login_pword", int'(got_pword), int'(seq[i]));
      m_dc = (i == 2) ? 0 : m_dc + 1;
      check_eq("login_digits", int'(digit_count), m_dc);
      check_eq("login_fails", int'(fail_count), 0);
    end
    logout(1'b1);

    // Three failed attempts into lockout.
    for (int a = 0; a < Mf; a++) attempt(1'b0, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      pass = ($urandom_range(0, 1) == 0);
      attempt(pass, $urandom_range(0, 3), 1'b0);
      if (pass) logout(1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-lockout.
    while (m_fc < Mf - 1) attempt(1'b0, 0, 1'b0);
    attempt(1'b0, 0, 1'b1);
    check_eq("pre_rst_locked", int'(locked), 1);
    RST = 1'b0;
    #2 check_reset_outs("rst_lock");
    btn_enter = 1'b1;
    step();
    step();
    RST = 1'b1;
    m_dc = 0;
    m_fc = 0;
    s0 = n_strobe;
    repeat (12) step();
    check_eq("rst_lock_nostrobe", n_strobe - s0, 0);
    check_eq("rst_lock_unlocked", int'(locked), 0);

    // Reset asserted mid-debounce.
    sw_digit  = 4'd9;
    btn_enter = 1'b0;
    repeat (4) step();
    RST = 1'b0;
    #2 check_reset_outs("rst_press");
    btn_enter = 1'b1;
    step();
    step();
    RST = 1'b1;
    s0 = n_strobe;
    repeat (12) step();
    check_eq("rst_press_nostrobe", n_strobe - s0, 0);
    check_eq("rst_press_digits", int'(digit_count), 0);
    s0 = n_strobe;
    press(4'd6, 0, 8, 0, 8);
    check_eq("post_rst_strobe", n_strobe - s0, 1);
    check_eq("post_rst_pword", int'(got_pword), 6);
    check_eq("post_rst_digits", int'(digit_count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
